// File: rtl/prop_sweep_seq.sv
// Propagation-delay sweep sequencer: walks a slope x capacitance grid, times the cell response in clock cycles
// and keeps {rise, fall} per point in a readable table. Define CHAR_FALL_MEAS_EN to measure the fall delay too.
module prop_sweep_seq #(
    parameter int NB_SLOPES = 7,
    parameter int NB_CAPA   = 7,
    parameter int TICK      = 7,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1000,
    parameter int INVERTING = 1,
    localparam int SLOPE_W  = (NB_SLOPES > 1) ? $clog2(NB_SLOPES) : 1,
    localparam int CAPA_W   = (NB_CAPA > 1) ? $clog2(NB_CAPA) : 1,
    localparam int ADDR_W   = (NB_SLOPES * NB_CAPA > 1) ? $clog2(NB_SLOPES * NB_CAPA) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [SLOPE_W-1:0]   slope_idx,
    output logic [CAPA_W-1:0]    capa_idx,
    output logic                 cfg_strobe,
    output logic                 din,
    input  logic                 dout,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [2*CNT_W-1:0]   rd_data
);

    localparam int NB_PTS = NB_SLOPES * NB_CAPA;
    localparam int TICK_W = (TICK > 1) ? $clog2(TICK) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICK - 1);
    localparam logic [TICK_W-1:0]  TICK_ONE    = TICK_W'(1);
    localparam logic [SLOPE_W-1:0] SLOPE_LAST  = SLOPE_W'(NB_SLOPES - 1);
    localparam logic [SLOPE_W-1:0] SLOPE_ONE   = SLOPE_W'(1);
    localparam logic [CAPA_W-1:0]  CAPA_LAST   = CAPA_W'(NB_CAPA - 1);
    localparam logic [CAPA_W-1:0]  CAPA_ONE    = CAPA_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_SAT     = {CNT_W{1'b1}};

    // Settled response level after a rising / falling stimulus edge
    localparam logic EXP_RISE = (INVERTING != 0) ? 1'b0 : 1'b1;
    localparam logic EXP_FALL = ~EXP_RISE;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SLOPE  = 3'd1;
    localparam logic [2:0] S_CAPA   = 3'd2;
    localparam logic [2:0] S_MEAS_R = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_MEAS_F = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]        state;
    logic [TICK_W-1:0] tick_cnt;
    logic [CNT_W-1:0]  meas_cnt;

    logic              tick_end;
    logic              rise_hit;
    logic              meas_expired;
    logic              rise_we;
    logic              fall_we;
    logic              rise_timeout;
    logic              fall_timeout;
    logic [CNT_W-1:0]  rise_val;
    logic [CNT_W-1:0]  fall_val;
    logic [ADDR_W-1:0] wr_addr;

    logic [CNT_W-1:0]  rise_mem [0:NB_PTS-1];
    logic [CNT_W-1:0]  fall_mem [0:NB_PTS-1];

    assign wr_addr = ADDR_W'(int'(slope_idx) * NB_CAPA + int'(capa_idx));

`ifdef CHAR_FALL_MEAS_EN
    logic fall_hit;
    assign fall_hit = (dout == EXP_FALL);
`endif

    // A match on the same edge the count reaches TIMEOUT still counts as a valid delay
    always_comb begin
        tick_end     = (tick_cnt == TICK_LAST);
        rise_hit     = (dout == EXP_RISE);
        meas_expired = (meas_cnt == CNT_TIMEOUT);
        rise_we      = 1'b0;
        fall_we      = 1'b0;
        rise_timeout = 1'b0;
        fall_timeout = 1'b0;
        rise_val     = meas_cnt;
        fall_val     = '0;
        if (!rst) begin
            if (state == S_MEAS_R && (rise_hit || meas_expired)) begin
                rise_we      = 1'b1;
                rise_timeout = !rise_hit;
                rise_val     = rise_hit ? meas_cnt : CNT_SAT;
            end
`ifdef CHAR_FALL_MEAS_EN
            if (state == S_MEAS_F && (fall_hit || meas_expired)) begin
                fall_we      = 1'b1;
                fall_timeout = !fall_hit;
                fall_val     = fall_hit ? meas_cnt : CNT_SAT;
            end
`else
            if (state == S_MEAS_F) begin
                fall_we = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            meas_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cfg_strobe <= 1'b0;
            din        <= 1'b0;
            slope_idx  <= '0;
            capa_idx   <= '0;
        end else begin
            cfg_strobe <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_SLOPE;
                        tick_cnt   <= '0;
                        slope_idx  <= '0;
                        capa_idx   <= '0;
                        cfg_strobe <= 1'b1;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        din        <= 1'b0;
                    end
                end
                S_SLOPE: begin
                    if (tick_end) begin
                        state    <= S_CAPA;
                        tick_cnt <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end
                S_CAPA: begin
                    if (tick_end) begin
                        state    <= S_MEAS_R;
                        tick_cnt <= '0;
                        meas_cnt <= CNT_ONE;
                        din      <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end
                S_MEAS_R: begin
                    if (rise_we) begin
                        state <= S_HOLD;
                        if (rise_timeout) begin
                            err <= 1'b1;
                        end
                    end else begin
                        meas_cnt <= meas_cnt + CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (tick_end) begin
                        state    <= S_MEAS_F;
                        tick_cnt <= '0;
                        meas_cnt <= CNT_ONE;
                        din      <= 1'b0;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end
                S_MEAS_F: begin
                    if (fall_we) begin
                        state <= S_GAP;
                        if (fall_timeout) begin
                            err <= 1'b1;
                        end
                    end else begin
                        meas_cnt <= meas_cnt + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (tick_end) begin
                        tick_cnt <= '0;
                        if (capa_idx != CAPA_LAST) begin
                            capa_idx   <= capa_idx + CAPA_ONE;
                            cfg_strobe <= 1'b1;
                            state      <= S_CAPA;
                        end else if (slope_idx != SLOPE_LAST) begin
                            slope_idx  <= slope_idx + SLOPE_ONE;
                            capa_idx   <= '0;
                            cfg_strobe <= 1'b1;
                            state      <= S_SLOPE;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Result table has no reset: entries keep their last measurement across sweeps
    always_ff @(posedge clk) begin
        if (rise_we) begin
            rise_mem[wr_addr] <= rise_val;
        end
        if (fall_we) begin
            fall_mem[wr_addr] <= fall_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (int'(rd_addr) < NB_PTS) begin
            rd_data <= {rise_mem[rd_addr], fall_mem[rd_addr]};
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_prop_sweep_seq.sv
// Directed bench for prop_sweep_seq on a 2x3 grid; a segment-level timeline and result-table model are
// compared against the DUT every cycle. Fall expectations follow CHAR_FALL_MEAS_EN for this compile.
module tb_prop_sweep_seq;

    localparam int NS = 2;
    localparam int NC = 3;
    localparam int TK = 4;
    localparam int CW = 8;
    localparam int TO = 20;

`ifdef CHAR_FALL_MEAS_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dout;
    logic [2:0]  rd_addr = 3'd0;
    logic        busy;
    logic        done;
    logic        err;
    logic [0:0]  slope_idx;
    logic [1:0]  capa_idx;
    logic        cfg_strobe;
    logic        din;
    logic [15:0] rd_data;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       strobe;
        logic [0:0] slope;
        logic [1:0] capa;
        logic       din;
        logic       err;
    } exp_t;

    exp_t        expQ[$];
    exp_t        cur;
    logic [15:0] expMem [0:5];
    int          checks = 0;
    int          errors = 0;
    int          mode = 0;
    int          dly;
    int          busyCyc = 0;
    int          strobeCnt = 0;
    logic [15:0] hist = '0;

    prop_sweep_seq #(
        .NB_SLOPES (NS),
        .NB_CAPA   (NC),
        .TICK      (TK),
        .CNT_W     (CW),
        .TIMEOUT   (TO),
        .INVERTING (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .slope_idx  (slope_idx),
        .capa_idx   (capa_idx),
        .cfg_strobe (cfg_strobe),
        .din        (din),
        .dout       (dout),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Cell model: mode 0 inverter with 3-cycle delay, mode 1 delay 2+slope+capa, mode 2 output stuck high
    always @(posedge clk) hist <= {hist[14:0], din};

    always_comb begin
        dly = (mode == 1) ? 2 + int'(slope_idx) + int'(capa_idx) : 3;
        if (mode == 2) dout = 1'b1;
        else dout = ~hist[dly-2];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (busy) busyCyc++;
        if (cfg_strobe) strobeCnt++;
    end

    // One expected-output entry is consumed per clock while the model queue is non-empty
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            checkOutput("busy", 32'(busy), 32'(cur.busy));
            checkOutput("done", 32'(done), 32'(cur.done));
            checkOutput("cfg_strobe", 32'(cfg_strobe), 32'(cur.strobe));
            checkOutput("slope_idx", 32'(slope_idx), 32'(cur.slope));
            checkOutput("capa_idx", 32'(capa_idx), 32'(cur.capa));
            checkOutput("din", 32'(din), 32'(cur.din));
            checkOutput("err", 32'(err), 32'(cur.err));
        end
    end

    function automatic int pointDelay(input int m, input int s, input int c);
        return (m == 1) ? 2 + s + c : 3;
    endfunction

    function automatic int riseCycles(input int m, input int s, input int c);
        return (m == 2) ? TO : pointDelay(m, s, c);
    endfunction

    function automatic int riseStored(input int m, input int s, input int c);
        return (m == 2) ? 255 : pointDelay(m, s, c);
    endfunction

    function automatic int fallCycles(input int m, input int s, input int c);
        if (!FALL_EN || m == 2) return 1;
        return pointDelay(m, s, c);
    endfunction

    function automatic int fallStored(input int m, input int s, input int c);
        if (!FALL_EN) return 0;
        return (m == 2) ? 1 : pointDelay(m, s, c);
    endfunction

    function automatic int countBusy();
        int n = 0;
        foreach (expQ[i]) if (expQ[i].busy) n++;
        return n;
    endfunction

    task automatic pushEntry(input logic b, input logic d, input logic st, input int s, input int c,
                             input logic di, input logic e);
        exp_t x;
        x.busy   = b;
        x.done   = d;
        x.strobe = st;
        x.slope  = 1'(s);
        x.capa   = 2'(c);
        x.din    = di;
        x.err    = e;
        expQ.push_back(x);
    endtask

    task automatic pushSeg(input int n, input int s, input int c, input logic di, input logic e,
                           input logic strobeFirst);
        for (int i = 0; i < n; i++) pushEntry(1'b1, 1'b0, strobeFirst && (i == 0), s, c, di, e);
    endtask

    // Timeline per point: [SLOPE on new slope] CAPA, rise wait, HOLD, fall wait, GAP; then DONE and idle
    task automatic buildSweep(input int m, input int keepPts);
        logic errf;
        errf = 1'b0;
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < NC; c++) begin
                if (c == 0) pushSeg(TK, s, c, 1'b0, errf, 1'b1);
                pushSeg(TK, s, c, 1'b0, errf, c != 0);
                pushSeg(riseCycles(m, s, c), s, c, 1'b1, errf, 1'b0);
                if (m == 2) errf = 1'b1;
                pushSeg(TK, s, c, 1'b1, errf, 1'b0);
                pushSeg(fallCycles(m, s, c), s, c, 1'b0, errf, 1'b0);
                pushSeg(TK, s, c, 1'b0, errf, 1'b0);
                if (s * NC + c < keepPts)
                    expMem[s*NC+c] = {8'(riseStored(m, s, c)), 8'(fallStored(m, s, c))};
            end
        end
        pushEntry(1'b0, 1'b1, 1'b0, NS - 1, NC - 1, 1'b0, errf);
        pushEntry(1'b0, 1'b0, 1'b0, NS - 1, NC - 1, 1'b0, errf);
        pushEntry(1'b0, 1'b0, 1'b0, NS - 1, NC - 1, 1'b0, errf);
    endtask

    // poke: 0 none, 1 extra start while busy, 2 start during the DONE cycle
    task automatic applyStimulus(input int m, input int litBusy, input int poke);
        bit poked;
        poked = 1'b0;
        @(negedge clk);
        mode = m;
        buildSweep(m, 6);
        checkOutput("model_busy_len", 32'(countBusy()), 32'(litBusy));
        busyCyc = 0;
        strobeCnt = 0;
        start = 1'b1;
        for (int i = 0; i < 3000 && expQ.size() > 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke == 1 && i == 40) start = 1'b1;
            if (poke == 2 && expQ.size() == 2 && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        start = 1'b0;
        checkOutput("sweep_drained", 32'(expQ.size()), 32'd0);
        checkOutput("busy_cycles", 32'(busyCyc), 32'(litBusy));
        checkOutput("strobe_count", 32'(strobeCnt), 32'd6);
    endtask

    task automatic readOne(input int a, input logic [15:0] req, input string name);
        @(negedge clk);
        rd_addr = 3'(a);
        @(posedge clk);
        #1;
        checkOutput(name, 32'(rd_data), 32'(req));
    endtask

    task automatic readAll();
        for (int a = 0; a < 8; a++) readOne(a, (a < 6) ? expMem[a] : 16'h0000, $sformatf("rd_data[%0d]", a));
    endtask

    task automatic abortSweep();
        bit found;
        found = 1'b0;
        @(negedge clk);
        mode = 1;
        buildSweep(1, 4);
        start = 1'b1;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (slope_idx == 1'b1 && capa_idx == 2'd1 && din) found = 1'b1;
        end
        checkOutput("abort_point_reached", 32'(found), 32'd1);
        rst = 1'b1;
        expQ.delete();
        pushEntry(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("abort_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_strobe", 32'(cfg_strobe), 32'd0);
        checkOutput("rst_din", 32'(din), 32'd0);
        checkOutput("rst_slope", 32'(slope_idx), 32'd0);
        checkOutput("rst_capa", 32'(capa_idx), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed 3-cycle inverter: 6 x (4+3+4+3+4) + 2 x 4, or fall wait of one cycle when not measured
        applyStimulus(0, FALL_EN ? 116 : 104, 0);
        readAll();
        readOne(0, FALL_EN ? 16'h0303 : 16'h0300, "lit_fixed_addr0");

        // Stuck output: every rise times out, extra start mid-sweep must be ignored
        applyStimulus(2, 206, 1);
        readAll();
        readOne(2, FALL_EN ? 16'hFF01 : 16'hFF00, "lit_stuck_addr2");
        checkOutput("stuck_err_after", 32'(err), 32'd1);

        // Reset in the rise wait of point (1,1): earlier points rewritten, (1,1) untouched
        abortSweep();
        readOne(3, FALL_EN ? 16'h0303 : 16'h0300, "lit_abort_addr3");
        readOne(4, FALL_EN ? 16'hFF01 : 16'hFF00, "lit_abort_addr4");
        readAll();

        // Full sweep after the abort, with a start pulse in the DONE cycle
        applyStimulus(0, FALL_EN ? 116 : 104, 2);
        readAll();

        applyStimulus(1, FALL_EN ? 122 : 107, 0);
        readAll();
        readOne(5, FALL_EN ? 16'h0505 : 16'h0500, "lit_var_addr5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
